adder_share_arbiter: RTL and testbench
======================================

// Module: adder_share_arbiter
// PURPOSE
//  Shares one WIDTH-bit ripple-carry adder instance (carry-in tied 0) between two requesters.
//  Round-robin arbitration; valid/ready handshake on each request port and on the single response port.
//  Sits between the requesting blocks and the adder, which is instantiated beside it at top level.
//  Registers the operands before the adder and the result after it, so the adder's full ripple path gets one whole cycle.
// PARAMETERS
//  WIDTH      8    operand/sum width; must equal the adder width
//  CNT_W      16   width of the saturating completed-operation counter
// PORTS
//  clk          in   1       rising-edge clock, sole clock domain
//  reset_n      in   1       asynchronous active-low reset
//  req0_valid   in   1       requester 0 has operands
//  req0_a       in   WIDTH   requester 0 operand a
//  req0_b       in   WIDTH   requester 0 operand b
//  req0_ready   out  1       requester 0 accepted this cycle when valid&ready
//  req1_valid   in   1       requester 1 has operands
//  req1_a       in   WIDTH   requester 1 operand a
//  req1_b       in   WIDTH   requester 1 operand b
//  req1_ready   out  1       requester 1 accepted this cycle when valid&ready
//  add_a        out  WIDTH   registered operand a to shared adder
//  add_b        out  WIDTH   registered operand b to shared adder
//  add_sum      in   WIDTH   adder sum (combinational from add_a/add_b)
//  add_cout     in   1       adder carry-out
//  rsp_valid    out  1       response held valid until accepted
//  rsp_ready    in   1       consumer accepts response when valid&ready
//  rsp_id       out  1       index of requester that owns the response
//  rsp_sum      out  WIDTH   registered sum
//  rsp_cout     out  1       registered carry-out
//  busy         out  1       high in ISSUE or RESP
//  op_count     out  CNT_W   responses accepted since reset, saturating
// BEHAVIOUR
//  Reset: async on reset_n=0. State=IDLE. add_a, add_b, rsp_sum, rsp_cout, rsp_id and op_count = 0.
//   rsp_valid=0, busy=0. last_grant=1, so requester 0 wins the first contention.
//  FSM IDLE -> ISSUE -> RESP -> IDLE. Exactly one operation in flight.
//  IDLE:
//   - reqN_ready is combinational. Only one is high, and only for the winner; both are 0 in ISSUE and RESP.
//   - Only req0 valid: grant 0. Only req1 valid: grant 1.
//   - Both valid: grant !last_grant.
//   - On grant, at the clock edge: add_a/add_b <= winner operands; id <= winner; last_grant <= winner; state -> ISSUE.
//   - No valid: stay in IDLE with both ready lines 0.
//  ISSUE (one cycle):
//   - At the edge: rsp_sum <= add_sum, rsp_cout <= add_cout, rsp_id <= id; state -> RESP.
//   - add_a/add_b keep their values until the next grant.
//  RESP:
//   - rsp_valid=1. rsp_sum, rsp_cout and rsp_id stay stable while rsp_ready=0, for unbounded backpressure.
//   - On rsp_valid&rsp_ready: state -> IDLE; op_count += 1, saturating at 2^CNT_W-1.
//   - No new grant is issued in the same cycle, so re-arbitration happens in the following IDLE cycle.
//  Latency: handshake at edge T -> rsp_valid first high in the cycle after edge T+1. Throughput is 1 op per 3 cycles, best case.
//  Arithmetic: rsp_sum = (a+b) mod 2^WIDTH; rsp_cout = carry of a+b. No sign interpretation.
//  Requester changing valid/operands while not ready: ignored, no capture.
//  Reset mid-ISSUE/RESP: the in-flight op is discarded and no response is produced. Outputs take reset values immediately.
// TESTING
//  1 Reset, then req0 a=8'h12 b=8'h34 alone -> req0_ready at T; rsp_valid 2 cycles later; rsp_id=0, sum=8'h46, cout=0.
//  2 req1 a=8'hFF b=8'h01 -> sum=8'h00, cout=1, rsp_id=1. Also a=8'hFF b=8'hFF -> sum=8'hFE, cout=1.
//  3 Both valid continuously from reset, rsp_ready=1 -> grants alternate 0,1,0,1; ops every 3 cycles; op_count=4 after 4 responses.
//  4 rsp_ready=0 for 10 cycles in RESP -> rsp_* stable, both ready=0, busy=1. Release -> one accept, return to IDLE.
//  5 Assert reset_n=0 during ISSUE -> rsp_valid never rises. After release, req0 is granted first on contention.
//  6 CNT_W=2, 5 accepted ops -> op_count saturates at 3.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// Round-robin front end that time-shares one external ripple-carry adder
// between two valid/ready requesters, with registered operands and result.
//
// Ports:
//   clk, reset_n             clock, async active-low reset
//   req{0,1}_valid/_a/_b     requester operand handshakes
//   req{0,1}_ready           grant, combinational, IDLE only
//   add_a, add_b             registered operands to the shared adder
//   add_sum, add_cout        combinational adder result
//   rsp_valid/_ready         response handshake
//   rsp_id/_sum/_cout        owner and registered result
//   busy                     operation in flight (ISSUE or RESP)
//   op_count                 saturating count of accepted responses
module adder_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             rid_q, rid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             g0, g1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    rid_d   = rid_q;
    cnt_d   = cnt_q;
    g0      = 1'b0;
    g1      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // last_q=1 favours requester 0 on contention
        g0 = req0_valid & (~req1_valid | last_q);
        g1 = req1_valid & (~req0_valid | ~last_q);
        if (g0) begin
          a_d     = req0_a;
          b_d     = req0_b;
          id_d    = 1'b0;
          last_d  = 1'b0;
          state_d = ISSUE;
        end else if (g1) begin
          a_d     = req1_a;
          b_d     = req1_b;
          id_d    = 1'b1;
          last_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        sum_d   = add_sum;
        cout_d  = add_cout;
        rid_d   = id_q;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      rid_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      rid_q   <= rid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req0_ready = g0;
  assign req1_ready = g1;
  assign add_a      = a_q;
  assign add_b      = b_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rid_q;
  assign rsp_sum    = sum_q;
  assign rsp_cout   = cout_q;
  assign busy       = (state_q != IDLE);
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a behavioural adder beside it.
// A second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_adder_share_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0_valid, req1_valid, rsp_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;

  logic        r0_rdy, r1_rdy, rv, rid, rcout, bsy;
  logic [7:0]  aa, ab, asum, rsum;
  logic        acout;
  logic [15:0] cnt;

  logic        r0_rdy2, r1_rdy2, rv2, rid2, rcout2, bsy2;
  logic [7:0]  aa2, ab2, asum2, rsum2;
  logic        acout2;
  logic [1:0]  cnt2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign {acout, asum}   = {1'b0, aa} + {1'b0, ab};
  assign {acout2, asum2} = {1'b0, aa2} + {1'b0, ab2};

  adder_share_arbiter #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(r0_rdy),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(r1_rdy),
    .add_a(aa), .add_b(ab), .add_sum(asum), .add_cout(acout),
    .rsp_valid(rv), .rsp_ready(rsp_ready), .rsp_id(rid),
    .rsp_sum(rsum), .rsp_cout(rcout), .busy(bsy), .op_count(cnt)
  );

  adder_share_arbiter #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(r0_rdy2),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(r1_rdy2),
    .add_a(aa2), .add_b(ab2), .add_sum(asum2), .add_cout(acout2),
    .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_id(rid2),
    .rsp_sum(rsum2), .rsp_cout(rcout2), .busy(bsy2), .op_count(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs settle 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    #1;
  endtask

  // One uncontended operation with rsp_ready asserted once valid.
  task automatic single(input logic r, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] es,
                        input logic ec, input logic [15:0] ecnt);
    if (r) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    #1;
    chk("grant_r0", r0_rdy, !r);
    chk("grant_r1", r1_rdy, r);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("issue_busy", bsy, 1'b1);
    chk("issue_rv", rv, 1'b0);
    chk("issue_add_a", aa, a);
    chk("issue_add_b", ab, b);
    tick();
    chk("resp_rv", rv, 1'b1);
    chk("resp_id", rid, r);
    chk("resp_sum", rsum, es);
    chk("resp_cout", rcout, ec);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("done_rv", rv, 1'b0);
    chk("done_busy", bsy, 1'b0);
    chk("done_cnt", cnt, ecnt);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_rv", rv, 1'b0);
    chk("rst_busy", bsy, 1'b0);
    chk("rst_cnt", cnt, 16'd0);
    chk("rst_sum", rsum, 8'd0);
    chk("rst_add_a", aa, 8'd0);
    chk("rst_rdy0", r0_rdy, 1'b0);
    chk("rst_rdy1", r1_rdy, 1'b0);

    // Single requests, including carry-out cases
    single(1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 16'd1);
    single(1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, 16'd2);
    single(1'b1, 8'hFF, 8'hFF, 8'hFE, 1'b1, 16'd3);
    single(1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 16'd4);

    // Backpressure: 10 cycles held in RESP with requests pending
    req0_valid = 1'b1; req0_a = 8'h5A; req0_b = 8'h0F;
    tick();
    req0_valid = 1'b0;
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'hAA; req1_a = 8'hBB;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_rv", rv, 1'b1);
      chk("bp_sum", rsum, 8'h69);
      chk("bp_cout", rcout, 1'b0);
      chk("bp_id", rid, 1'b0);
      chk("bp_busy", bsy, 1'b1);
      chk("bp_rdy", {r0_rdy, r1_rdy}, 2'b00);
      tick();
    end
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("bp_rel_rv", rv, 1'b0);
    chk("bp_rel_busy", bsy, 1'b0);
    chk("bp_rel_cnt", cnt, 16'd5);

    // Continuous contention from reset: grants alternate 0,1,0,1,0
    do_reset();
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02;
    req1_valid = 1'b1; req1_a = 8'h10; req1_b = 8'h20;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_rdy0", r0_rdy, (k % 2) == 0);
      chk("rr_rdy1", r1_rdy, (k % 2) == 1);
      tick();
      chk("rr_issue_rv", rv, 1'b0);
      tick();
      chk("rr_rv", rv, 1'b1);
      chk("rr_id", rid, (k % 2) == 1);
      chk("rr_sum", rsum, (k % 2) ? 8'h30 : 8'h03);
      tick();
      if (k == 3) chk("rr_cnt4", cnt, 16'd4);
      if (k == 2) chk("sat_cnt3", cnt2, 2'd3);
    end
    chk("rr_cnt5", cnt, 16'd5);
    chk("sat_cnt5", cnt2, 2'd3);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    tick(); tick(); tick();

    // Reset during ISSUE after requester 0 won the last grant
    req0_valid = 1'b1; req0_a = 8'h21; req0_b = 8'h21;
    rsp_ready = 1'b1;
    tick();
    req0_valid = 1'b0;
    chk("mid_busy", bsy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", bsy, 1'b0);
    chk("mid_rst_cnt", cnt, 16'd0);
    chk("mid_rst_add_a", aa, 8'd0);
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mid_no_rv", rv, 1'b0);
      tick();
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("post_rst_rdy0", r0_rdy, 1'b1);
    chk("post_rst_rdy1", r1_rdy, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
